vram_write_snoop: RTL and testbench
===================================

# vram_write_snoop

Captures Mac SE 68000 CPU write cycles that land in the main or alternate screen buffer, queues them, and replays them as byte writes into the external VRAM. It is the writer that fills the VRAM the video output path reads. It runs in the pixClk domain, is asynchronous to the CPU bus, and only drives the VRAM bus inside write windows granted by the video timing logic.

## Interface
- DEPTH, 4: FIFO entries (power of two, ≥2); each entry is one CPU write cycle.
- pixClk  in  1  25.175 MHz pixel clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpuAddr  in  23  CPU word address [23:1].
- cpuData  in  16  CPU data bus.
- ncpuAS, ncpuUDS, ncpuLDS  in  1 each  CPU strobes, active-low, asynchronous to pixClk.
- cpuRnW  in  1  1 = read, 0 = write.
- ramSize  in  3  RAM top: 000 = 0x100000; 001 = 0x200000; 010 = 0x280000; all others = 0x400000.
- wrWindow  in  1  high = a VRAM write may start this cycle.
- vramAddr  out  15  VRAM byte address.
- vramDataOut  out  8  write data.
- vramDataOE  out  1  enables the VRAM data bus driver.
- nvramWE  out  1  VRAM write strobe, active-low.
- nvramCE0, nvramCE1  out  1 each  chip selects for main and alternate buffers, active-low.
- fifoEmpty  out  1  queue empty.
- overflow  out  1  sticky: a write was dropped.

## Operation
- Synchronise ncpuAS, ncpuUDS, ncpuLDS and cpuRnW through 2 flops each. Define cpuWr as: AS asserted, RnW low, and at least one DS asserted, all using the synced signals.
- On the rising edge of cpuWr, sample cpuAddr, cpuData and the synced UDS/LDS directly. Compute the byte address A = {cpuAddr, 1'b0}.
- Main base = top − 0x5900. Alternate base = top − 0xD900.
- The write hits a buffer when 0 ≤ A − base ≤ 0x557F. If it hits, push an entry {buf, offset[14:0], data, uds, lds}. Otherwise discard it.
- Push when the FIFO is full: drop the entry and set overflow. A full FIFO with a push and a pop in the same cycle accepts the push.
- Write engine FSM: IDLE → SETUP → STROBE → HOLD → IDLE.
  - IDLE: if the FIFO is not empty and wrWindow = 1, go to SETUP.
  - SETUP: drive vramAddr and vramDataOut, vramDataOE = 1, selected CE low.
  - STROBE: nvramWE low.
  - HOLD: nvramWE high, address and data held. Leaving HOLD releases CE and OE.
- Upper byte: vramAddr = offset, data[15:8]. Lower byte: vramAddr = offset | 1, data[7:0].
- An entry with both strobes produces the upper write first, then the lower write. Each write needs its own wrWindow start.
- The entry pops after its last byte's HOLD.
- wrWindow falling during SETUP, STROBE or HOLD does not abort the write. Video timing guarantees 3 free cycles per window start.
- overflow clears only on reset.

## Timing
- Reset values: vramAddr 0, vramDataOut 0, vramDataOE 0, nvramWE 1, nvramCE0 1, nvramCE1 1, fifoEmpty 1, overflow 0, FSM IDLE, FIFO empty.
- Reset takes effect immediately, including mid-write: nvramWE goes high asynchronously.
- Capture occurs on the 3rd pixClk edge after the strobes fall: 2 synchroniser edges plus 1 edge-detect edge. fifoEmpty falls 1 cycle after capture.
- Best-case latency from capture to nvramWE low is 3 cycles (IDLE sees the entry, SETUP, STROBE).
- One byte occupies exactly 3 cycles of bus ownership, and nvramWE is low for exactly 1 cycle.
- A new capture needs cpuWr to deassert and reassert. A strobe held for many cycles produces exactly one entry.

## Test plan
- Main word write: ramSize = 000, cpuAddr = 0x7D380, data 0xA55A, both strobes. Expect two CE0 writes: addr 0x0000 with data 0xA5, then addr 0x0001 with data 0x5A. nvramWE pulses for 1 cycle each.
- Boundary: ramSize = 000, LDS only, cpuAddr = 0x7FE3F. Expect a CE0 write to addr 0x557F. The same write to cpuAddr = 0x7FE40 produces no VRAM activity.
- Alternate buffer: ramSize = 011, cpuAddr = 0x1F9380, UDS only, data 0x3Cxx. Expect a CE1 write to addr 0x0000 with data 0x3C. CE0 stays high.
- Read cycle: cpuRnW = 1 to the main base address. Expect no push, and fifoEmpty stays 1.
- Overflow: hold wrWindow = 0 and issue 5 writes with DEPTH = 4. Expect overflow = 1. After releasing wrWindow, exactly 4 entries are written in order.
- Reset mid-write: assert reset during STROBE. Expect nvramWE = 1 and both CEs = 1 with no clock edge. After release, fifoEmpty = 1 and overflow = 0.

Source files
------------

// File: rtl/vram_write_snoop.sv
// vram_write_snoop: snoops 68000 writes to the main/alternate screen buffers
// and replays them as byte writes into external VRAM inside video write windows.
// Ports:
//   pixClk, reset                      pixel clock, async active-high reset
//   cpuAddr/cpuData/ncpuAS/ncpuUDS/ncpuLDS/cpuRnW
//                                      raw CPU bus (async)
//   ramSize                            selects top of RAM
//   wrWindow                           VRAM write may start
//   vramAddr/vramDataOut/vramDataOE/nvramWE/nvramCE0/nvramCE1
//                                      VRAM bus
//   fifoEmpty, overflow                queue status, sticky drop flag
module vram_write_snoop #(
    parameter int DEPTH = 4
) (
    input  logic        pixClk,
    input  logic        reset,
    input  logic [22:0] cpuAddr,
    input  logic [15:0] cpuData,
    input  logic        ncpuAS,
    input  logic        ncpuUDS,
    input  logic        ncpuLDS,
    input  logic        cpuRnW,
    input  logic [2:0]  ramSize,
    input  logic        wrWindow,
    output logic [14:0] vramAddr,
    output logic [7:0]  vramDataOut,
    output logic        vramDataOE,
    output logic        nvramWE,
    output logic        nvramCE0,
    output logic        nvramCE1,
    output logic        fifoEmpty,
    output logic        overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [23:0] MAIN_OFS = 24'h005900;
    localparam logic [23:0] ALT_OFS  = 24'h00D900;
    localparam logic [23:0] SPAN     = 24'h00557F;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
    state_t state, stateNext;

    logic [1:0]  asSync, udsSync, ldsSync, rnwSync;
    logic        cpuWr, cpuWrQ;
    logic        capValid, capUds, capLds;
    logic [23:0] capAddr;
    logic [15:0] capData;
    logic [23:0] ramTop, mainDiff, altDiff;
    logic        hitMain, hitAlt, push, pop, accept, full;
    logic [33:0] pushEntry, head;
    logic [33:0] mem [DEPTH];
    logic [PW-1:0] wrPtr, rdPtr;
    logic [PW:0] count;
    logic        load, doUpper, upperDone, curUpper, curBuf;
    logic [14:0] addrReg;
    logic [7:0]  dataReg;

    always_ff @(posedge pixClk or posedge reset) begin
        if (reset) begin
            asSync  <= 2'b11;
            udsSync <= 2'b11;
            ldsSync <= 2'b11;
            rnwSync <= 2'b11;
        end else begin
            asSync  <= {asSync[0], ncpuAS};
            udsSync <= {udsSync[0], ncpuUDS};
            ldsSync <= {ldsSync[0], ncpuLDS};
            rnwSync <= {rnwSync[0], cpuRnW};
        end
    end

    assign cpuWr = !asSync[1] && !rnwSync[1] && (!udsSync[1] || !ldsSync[1]);

    // Address/data are stable while the strobes are low, so they are
    // sampled raw once the synchronised strobes show a new write.
    always_ff @(posedge pixClk or posedge reset) begin
        if (reset) begin
            cpuWrQ   <= 1'b0;
            capValid <= 1'b0;
            capAddr  <= '0;
            capData  <= '0;
            capUds   <= 1'b0;
            capLds   <= 1'b0;
        end else begin
            cpuWrQ   <= cpuWr;
            capValid <= cpuWr && !cpuWrQ;
            if (cpuWr && !cpuWrQ) begin
                capAddr <= {cpuAddr, 1'b0};
                capData <= cpuData;
                capUds  <= !udsSync[1];
                capLds  <= !ldsSync[1];
            end
        end
    end

    always_comb begin
        unique case (ramSize)
            3'b000:  ramTop = 24'h100000;
            3'b001:  ramTop = 24'h200000;
            3'b010:  ramTop = 24'h280000;
            default: ramTop = 24'h400000;
        endcase
    end

    // Unsigned wrap makes addresses below the base compare as huge.
    assign mainDiff  = capAddr - (ramTop - MAIN_OFS);
    assign altDiff   = capAddr - (ramTop - ALT_OFS);
    assign hitMain   = mainDiff <= SPAN;
    assign hitAlt    = altDiff <= SPAN;
    assign push      = capValid && (hitMain || hitAlt);
    assign pushEntry = {!hitMain,
                        hitMain ? mainDiff[14:0] : altDiff[14:0],
                        capData, capUds, capLds};

    assign full      = count == (PW+1)'(DEPTH);
    assign fifoEmpty = count == '0;
    assign accept    = push && (!full || pop);
    assign head      = mem[rdPtr];

    always_ff @(posedge pixClk) begin
        if (accept) mem[wrPtr] <= pushEntry;
    end

    always_ff @(posedge pixClk or posedge reset) begin
        if (reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) wrPtr <= wrPtr + PW'(1);
            if (pop) rdPtr <= rdPtr + PW'(1);
            unique case ({accept, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
            if (push && !accept) overflow <= 1'b1;
        end
    end

    assign doUpper = head[1] && !upperDone;

    always_comb begin
        stateNext = state;
        load      = 1'b0;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifoEmpty && wrWindow) begin
                    stateNext = SETUP;
                    load      = 1'b1;
                end
            end
            SETUP:  stateNext = STROBE;
            STROBE: stateNext = HOLD;
            HOLD: begin
                stateNext = IDLE;
                pop       = !(curUpper && head[0]);
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge pixClk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            upperDone <= 1'b0;
            curUpper  <= 1'b0;
            curBuf    <= 1'b0;
            addrReg   <= '0;
            dataReg   <= '0;
        end else begin
            state <= stateNext;
            if (state == HOLD) upperDone <= curUpper && head[0];
            if (load) begin
                curUpper <= doUpper;
                curBuf   <= head[33];
                addrReg  <= doUpper ? head[32:18] : (head[32:18] | 15'h0001);
                dataReg  <= doUpper ? head[17:10] : head[9:2];
            end
        end
    end

    // Strobes decode straight from state so reset releases them at once.
    assign vramAddr    = addrReg;
    assign vramDataOut = dataReg;
    assign vramDataOE  = state != IDLE;
    assign nvramWE     = state != STROBE;
    assign nvramCE0    = !(state != IDLE && !curBuf);
    assign nvramCE1    = !(state != IDLE && curBuf);
endmodule

// File: tb/tb_vram_write_snoop.sv
// tb_vram_write_snoop: randomized and directed stimulus for vram_write_snoop,
// checked against a queue of expected VRAM byte writes.
module tb_vram_write_snoop;
    logic        pixClk;
    logic        reset;
    logic [22:0] cpuAddr;
    logic [15:0] cpuData;
    logic        ncpuAS, ncpuUDS, ncpuLDS, cpuRnW;
    logic [2:0]  ramSize;
    logic        wrWindow;
    logic [14:0] vramAddr;
    logic [7:0]  vramDataOut;
    logic        vramDataOE, nvramWE, nvramCE0, nvramCE1;
    logic        fifoEmpty, overflow;

    vram_write_snoop #(.DEPTH(4)) dut (
        .pixClk(pixClk), .reset(reset),
        .cpuAddr(cpuAddr), .cpuData(cpuData),
        .ncpuAS(ncpuAS), .ncpuUDS(ncpuUDS), .ncpuLDS(ncpuLDS),
        .cpuRnW(cpuRnW), .ramSize(ramSize), .wrWindow(wrWindow),
        .vramAddr(vramAddr), .vramDataOut(vramDataOut),
        .vramDataOE(vramDataOE), .nvramWE(nvramWE),
        .nvramCE0(nvramCE0), .nvramCE1(nvramCE1),
        .fifoEmpty(fifoEmpty), .overflow(overflow)
    );

    int nChecks = 0;
    int nPass   = 0;
    logic [23:0] expQ[$];
    bit  winRand  = 0;
    bit  winLevel = 0;
    bit  sawNotEmpty;
    int  weLow = 0;

    initial begin
        pixClk = 0;
        forever #20 pixClk = ~pixClk;
    end

    initial begin
        wrWindow = 0;
        forever begin
            @(negedge pixClk);
            wrWindow = winRand ? 1'($urandom_range(0, 1)) : winLevel;
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] got,
                            input logic [31:0] want);
        nChecks++;
        if (got === want) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    // Every VRAM strobe must match the oldest outstanding expected write.
    always @(negedge pixClk) begin : monitor
        logic [23:0] obs;
        logic [23:0] want;
        if (reset) begin
            weLow = 0;
        end else if (!nvramWE) begin
            weLow = weLow + 1;
            checkVal("oeDuringWe", vramDataOE, 1);
            checkVal("ceOneHot", nvramCE0 ^ nvramCE1, 1);
            obs = {!nvramCE1, vramAddr, vramDataOut};
            checkVal("writeExpected", expQ.size() > 0, 1);
            if (expQ.size() > 0) begin
                want = expQ.pop_front();
                checkVal("vramWrite", obs, want);
            end
        end else if (weLow > 0) begin
            checkVal("wePulseWidth", weLow, 1);
            weLow = 0;
        end
    end

    function automatic int ramTopOf(input logic [2:0] rs);
        case (rs)
            3'd0:    return 'h100000;
            3'd1:    return 'h200000;
            3'd2:    return 'h280000;
            default: return 'h400000;
        endcase
    endfunction

    task automatic modelWrite(input logic [2:0] rs, input logic [22:0] a,
                              input logic [15:0] d, input logic rnw,
                              input logic u, input logic l);
        int byteAddr, top, off;
        logic ce;
        bit hit;
        byteAddr = int'(a) * 2;
        top = ramTopOf(rs);
        hit = 0;
        ce  = 0;
        if (!rnw) begin
            off = byteAddr - (top - 'h5900);
            if (off >= 0 && off <= 'h557F) hit = 1;
            else begin
                off = byteAddr - (top - 'hD900);
                if (off >= 0 && off <= 'h557F) begin
                    hit = 1;
                    ce  = 1;
                end
            end
        end
        if (hit && u) expQ.push_back({ce, 15'(off), d[15:8]});
        if (hit && l) expQ.push_back({ce, 15'(off | 1), d[7:0]});
    endtask

    task automatic cpuWrite(input logic [22:0] a, input logic [15:0] d,
                            input logic rnw, input logic u, input logic l,
                            input int hold, input bit expectKept);
        if (expectKept) modelWrite(ramSize, a, d, rnw, u, l);
        sawNotEmpty = 0;
        @(negedge pixClk);
        cpuAddr = a;
        cpuData = d;
        cpuRnW  = rnw;
        ncpuAS  = 0;
        ncpuUDS = !u;
        ncpuLDS = !l;
        repeat (hold) begin
            @(negedge pixClk);
            if (!fifoEmpty) sawNotEmpty = 1;
        end
        ncpuAS  = 1;
        ncpuUDS = 1;
        ncpuLDS = 1;
        cpuRnW  = 1;
        repeat (3) begin
            @(negedge pixClk);
            if (!fifoEmpty) sawNotEmpty = 1;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge pixClk);
            n++;
        end while (!(fifoEmpty && nvramCE0 && nvramCE1) && n < 300);
        checkVal({tag, "Timeout"}, n < 300, 1);
        checkVal({tag, "Drained"}, expQ.size(), 0);
    endtask

    initial begin
        int feAt, weAt, top, base, delta, byteA, k;
        logic [1:0] s;
        reset   = 1;
        cpuAddr = '0;
        cpuData = '0;
        ncpuAS  = 1;
        ncpuUDS = 1;
        ncpuLDS = 1;
        cpuRnW  = 1;
        ramSize = 3'b000;
        repeat (3) @(negedge pixClk);
        checkVal("rstAddr", vramAddr, 0);
        checkVal("rstData", vramDataOut, 0);
        checkVal("rstOE", vramDataOE, 0);
        checkVal("rstWE", nvramWE, 1);
        checkVal("rstCE0", nvramCE0, 1);
        checkVal("rstCE1", nvramCE1, 1);
        checkVal("rstEmpty", fifoEmpty, 1);
        checkVal("rstOverflow", overflow, 0);
        reset = 0;
        winLevel = 1;
        repeat (2) @(negedge pixClk);

        // Main word write, long strobe, with latency measurement.
        modelWrite(3'b000, 23'h7D380, 16'hA55A, 0, 1, 1);
        @(negedge pixClk);
        cpuAddr = 23'h7D380;
        cpuData = 16'hA55A;
        cpuRnW  = 0;
        ncpuAS  = 0;
        ncpuUDS = 0;
        ncpuLDS = 0;
        feAt = 0;
        weAt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge pixClk);
            if (!fifoEmpty && feAt == 0) feAt = i;
            if (!nvramWE && weAt == 0) weAt = i;
        end
        ncpuAS  = 1;
        ncpuUDS = 1;
        ncpuLDS = 1;
        cpuRnW  = 1;
        checkVal("emptyFallCycle", feAt, 4);
        checkVal("weLatency", weAt, 6);
        drain("mainWord");

        // Last byte of the main buffer, then one word past it.
        cpuWrite(23'h7FE3F, 16'h1234, 0, 0, 1, 5, 1);
        drain("boundaryIn");
        cpuWrite(23'h7FE40, 16'h5678, 0, 0, 1, 5, 1);
        checkVal("boundaryOutNoPush", sawNotEmpty, 0);
        drain("boundaryOut");

        ramSize = 3'b011;
        cpuWrite(23'h1F9380, 16'h3C77, 0, 1, 0, 5, 1);
        drain("altBuf");

        ramSize = 3'b000;
        cpuWrite(23'h7D380, 16'hFFFF, 1, 1, 1, 6, 1);
        checkVal("readNoPush", sawNotEmpty, 0);
        drain("read");

        winRand = 1;
        for (int n = 0; n < 40; n++) begin
            ramSize = 3'($urandom_range(0, 7));
            top = ramTopOf(ramSize);
            k = $urandom_range(0, 2);
            if (k == 0) base = top - 'h5900;
            else if (k == 1) base = top - 'hD900;
            else base = $urandom_range(0, 'h3FFFFF);
            delta = int'($urandom_range(0, 'h5600)) - 'h40;
            byteA = base + delta;
            s = 2'($urandom_range(1, 3));
            cpuWrite(23'(byteA / 2), 16'($urandom), $urandom_range(0, 9) == 0,
                     s[1], s[0], $urandom_range(4, 10), 1);
            drain("rand");
        end
        winRand = 0;
        checkVal("noOverflowYet", overflow, 0);

        // Five writes with no window: the fifth is dropped.
        winLevel = 0;
        ramSize  = 3'b000;
        repeat (2) @(negedge pixClk);
        for (int i = 0; i < 5; i++)
            cpuWrite(23'h7D380 + 23'(i * 16), 16'h1100 * 16'(i + 1) + 16'h0022,
                     0, 1, i % 2 == 0, 5, i < 4);
        checkVal("overflowSet", overflow, 1);
        checkVal("blockedNotEmpty", fifoEmpty, 0);
        checkVal("blockedNoWrite", expQ.size(), 6);
        winLevel = 1;
        drain("overflow");
        checkVal("overflowSticky", overflow, 1);

        // Reset while the strobe is low.
        cpuWrite(23'h7D390, 16'hBEEF, 0, 1, 1, 0, 1);
        ncpuAS  = 0;
        ncpuUDS = 0;
        ncpuLDS = 0;
        cpuRnW  = 0;
        weAt = 0;
        for (int i = 1; i <= 20 && weAt == 0; i++) begin
            @(negedge pixClk);
            if (!nvramWE) weAt = i;
        end
        checkVal("midWriteReached", weAt != 0, 1);
        ncpuAS  = 1;
        ncpuUDS = 1;
        ncpuLDS = 1;
        cpuRnW  = 1;
        #5 reset = 1;
        #1;
        checkVal("asyncRstWE", nvramWE, 1);
        checkVal("asyncRstCE0", nvramCE0, 1);
        checkVal("asyncRstCE1", nvramCE1, 1);
        checkVal("asyncRstOE", vramDataOE, 0);
        expQ.delete();
        repeat (2) @(negedge pixClk);
        reset = 0;
        @(negedge pixClk);
        checkVal("postRstEmpty", fifoEmpty, 1);
        checkVal("postRstOverflow", overflow, 0);
        drain("postRst");

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
